// File: rtl/demux_frame_collector.sv
// -----------------------------------------------------------------------------
// demux_frame_collector
//
// Sits directly behind the 1-to-8 demux. It drives the round-robin channel
// select into the demux, takes one serial bit per accepted cycle, and places
// each bit into the frame position named by the select. Once all eight
// channel bits are in, the frame is held and offered to the consumer under a
// valid/ready handshake. While a frame is held, no new bits are taken. Any
// bit offered during that time is discarded and flagged on drop.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous, active-high reset (overrides every other input)
//   d            serial data bit from the demux path
//   d_valid      d is valid this cycle
//   d_ready      collector can accept a bit this cycle (combinational)
//   sync         start-of-frame marker, restarts the frame at channel 0
//   sel          current channel index, steers the demux select
//   y            assembled frame, y[k] is the channel-k bit
//   frame_valid  y holds a complete frame
//   frame_ready  consumer accepts the frame
//   drop         one-cycle pulse, a bit was offered while d_ready=0
// -----------------------------------------------------------------------------
module demux_frame_collector #(
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                d,
   input  logic                d_valid,
   output logic                d_ready,
   input  logic                sync,
   output logic [SEL_W-1:0]    sel,
   output logic [CHANNELS-1:0] y,
   output logic                frame_valid,
   input  logic                frame_ready,
   output logic                drop
);

   localparam logic [0:0] ST_COLLECT = 1'b0;
   localparam logic [0:0] ST_FULL    = 1'b1;

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);

   logic [0:0]          state;
   logic [0:0]          state_nxt;
   logic [SEL_W-1:0]    sel_nxt;
   logic [CHANNELS-1:0] y_nxt;

   // Both handshake flags decode straight from the state register.
   // frame_valid therefore comes from a flop, and d_ready has no path
   // from any input.
   assign d_ready     = (state == ST_COLLECT);
   assign frame_valid = (state == ST_FULL);

   // ---- next-state / frame assembly ----
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      y_nxt     = y;
      case (state)
         ST_COLLECT: begin
            if (sync) begin
               // Start-of-frame marker: throw away the partial frame. A bit
               // arriving with the marker belongs to channel 0.
               y_nxt = '0;
               if (d_valid) begin
                  y_nxt[0] = d;
                  sel_nxt  = SEL_W'(1);
               end else begin
                  sel_nxt  = '0;
               end
            end else if (d_valid) begin
               y_nxt[sel] = d;
               if (sel == LAST_SEL) begin
                  // Only a completed frame wraps the select back to 0.
                  sel_nxt   = '0;
                  state_nxt = ST_FULL;
               end else begin
                  sel_nxt   = sel + SEL_W'(1);
               end
            end
         end
         ST_FULL: begin
            // The frame is frozen. sync is ignored here, so a held frame
            // can never be destroyed before the consumer takes it.
            if (frame_ready) begin
               state_nxt = ST_COLLECT;
               y_nxt     = '0;
            end
         end
         default: begin
            state_nxt = ST_COLLECT;
         end
      endcase
   end

   // ---- registered state ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_COLLECT;
         sel   <= '0;
         y     <= '0;
         drop  <= 1'b0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         y     <= y_nxt;
         // The discarded bit leaves y and sel untouched. It is only reported.
         drop  <= d_valid & ~d_ready;
      end
   end

endmodule
